// File: rtl/counter_seq_ctrl.sv
// Wishbone-mapped sequencer for the 16-bit user counter: start/stop/pause, prescaler, compare match.
// Optional LA start/stop inputs are enabled with `define COUNTER_SEQ_LA_CTRL_EN.
module counter_seq_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned PRESC_W   = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic [15:0] cnt_value,
   output logic        cnt_en,
   output logic        cnt_clr,
   output logic        busy,
   output logic        irq
`ifdef COUNTER_SEQ_LA_CTRL_EN
   ,
   input  logic        la_start,
   input  logic        la_stop
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [PRESC_W-1:0] pcnt_q, pcnt_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [15:0]        compare_q, compare_d;
   logic               mode_q, mode_d;
   logic               irq_en_q, irq_en_d;
   logic               match_q, match_d;
   logic               start_q, start_d;
   logic               stop_q, stop_d;
   logic               clr_q, clr_d;
   logic               ack_q, ack_d;
   logic [31:0]        dat_q, dat_d;

   logic        hit, wr, ctrl_wr, status_w1c;
   logic [2:0]  off;
   logic [31:0] wmask, rdata;
   logic        la_start_rise, la_stop_rise;
   logic        start_cmd, stop_cmd, clr_cmd;
   logic        en_s, clr_s, match_set;
   logic        unused_sig;

   for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
      assign wmask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
   end

   assign unused_sig = ^{wbs_adr_i[1:0], wbs_dat_i, wmask};

`ifdef COUNTER_SEQ_LA_CTRL_EN
   logic la_start_q, la_start_prev_q, la_stop_q, la_stop_prev_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         la_start_q      <= 1'b0;
         la_start_prev_q <= 1'b0;
         la_stop_q       <= 1'b0;
         la_stop_prev_q  <= 1'b0;
      end else begin
         la_start_q      <= la_start;
         la_start_prev_q <= la_start_q;
         la_stop_q       <= la_stop;
         la_stop_prev_q  <= la_stop_q;
      end
   end

   assign la_start_rise = la_start_q & ~la_start_prev_q;
   assign la_stop_rise  = la_stop_q & ~la_stop_prev_q;
`else
   assign la_start_rise = 1'b0;
   assign la_stop_rise  = 1'b0;
`endif

   always_comb begin
      hit        = wbs_cyc_i & wbs_stb_i & ~ack_q & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
      wr         = hit & wbs_we_i;
      off        = wbs_adr_i[4:2];
      ctrl_wr    = wr & (off == 3'd0) & wbs_sel_i[0];
      status_w1c = wr & (off == 3'd1) & wbs_sel_i[0] & wbs_dat_i[2];

      mode_d    = ctrl_wr ? wbs_dat_i[2] : mode_q;
      irq_en_d  = ctrl_wr ? wbs_dat_i[3] : irq_en_q;
      start_d   = ctrl_wr & wbs_dat_i[0];
      stop_d    = ctrl_wr & wbs_dat_i[1];
      clr_d     = ctrl_wr & wbs_dat_i[4];
      presc_d   = presc_q;
      compare_d = compare_q;
      if (wr && off == 3'd2)
         presc_d = (presc_q & ~wmask[PRESC_W-1:0]) | (wbs_dat_i[PRESC_W-1:0] & wmask[PRESC_W-1:0]);
      if (wr && off == 3'd3)
         compare_d = (compare_q & ~wmask[15:0]) | (wbs_dat_i[15:0] & wmask[15:0]);

      case (off)
         3'd0:    rdata = {28'd0, irq_en_q, mode_q, 2'b00};
         3'd1:    rdata = {29'd0, match_q, state_q};
         3'd2:    rdata = 32'(presc_q);
         3'd3:    rdata = {16'd0, compare_q};
         3'd4:    rdata = {16'd0, cnt_value};
         default: rdata = 32'd0;
      endcase
      ack_d = hit;
      dat_d = (hit && !wbs_we_i) ? rdata : 32'd0;
   end

   always_comb begin
      start_cmd = start_q | la_start_rise;
      stop_cmd  = stop_q | la_stop_rise;
      clr_cmd   = clr_q;
      state_d   = state_q;
      pcnt_d    = pcnt_q;
      en_s      = 1'b0;
      clr_s     = 1'b0;
      match_set = 1'b0;

      // STOP beats START; a pending CLR suppresses the tick entirely.
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_cmd && !stop_cmd) begin
               state_d = ST_RUN;
               clr_s   = 1'b1;
               pcnt_d  = '0;
            end
         end
         ST_RUN: begin
            if (stop_cmd) begin
               state_d = ST_PAUSE;
            end else if (!clr_cmd) begin
               if (pcnt_q == presc_q) begin
                  pcnt_d = '0;
                  if (cnt_value == compare_q) begin
                     match_set = 1'b1;
                     if (mode_q) clr_s   = 1'b1;
                     else        state_d = ST_DONE;
                  end else begin
                     en_s = 1'b1;
                  end
               end else begin
                  pcnt_d = pcnt_q + PRESC_W'(1);
               end
            end
         end
         ST_PAUSE: begin
            if (start_cmd && !stop_cmd) state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase

      if (clr_cmd) begin
         clr_s  = 1'b1;
         pcnt_d = '0;
         if (state_d == ST_DONE) state_d = ST_IDLE;
      end
      match_d = match_set | (match_q & ~status_w1c);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= ST_IDLE;
         pcnt_q    <= '0;
         presc_q   <= '0;
         compare_q <= '0;
         mode_q    <= 1'b0;
         irq_en_q  <= 1'b0;
         match_q   <= 1'b0;
         start_q   <= 1'b0;
         stop_q    <= 1'b0;
         clr_q     <= 1'b0;
         ack_q     <= 1'b0;
         dat_q     <= '0;
      end else begin
         state_q   <= state_d;
         pcnt_q    <= pcnt_d;
         presc_q   <= presc_d;
         compare_q <= compare_d;
         mode_q    <= mode_d;
         irq_en_q  <= irq_en_d;
         match_q   <= match_d;
         start_q   <= start_d;
         stop_q    <= stop_d;
         clr_q     <= clr_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
      end
   end

   // Strobes are combinational so the counter moves on the same edge the tick is seen.
   assign cnt_en    = en_s & ~wb_rst_i;
   assign cnt_clr   = clr_s & ~wb_rst_i;
   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
   assign irq       = match_q & irq_en_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl: register table plus hand-written sequencing cases.
module tb_counter_seq_ctrl;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] dat_i = 32'h0, adr = 32'h0;
   logic        ack;
   logic [31:0] dat_o;
   logic [15:0] cnt_value = 16'h0;
   logic        cnt_en, cnt_clr, busy, irq;

   counter_seq_ctrl dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wbs_stb_i(stb),
      .wbs_cyc_i(cyc),
      .wbs_we_i (we),
      .wbs_sel_i(sel),
      .wbs_dat_i(dat_i),
      .wbs_adr_i(adr),
      .wbs_ack_o(ack),
      .wbs_dat_o(dat_o),
      .cnt_value(cnt_value),
      .cnt_en   (cnt_en),
      .cnt_clr  (cnt_clr),
      .busy     (busy),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   // External 16-bit counter that the controller sequences.
   always @(posedge clk) begin
      if (cnt_clr)     cnt_value <= 16'h0;
      else if (cnt_en) cnt_value <= cnt_value + 16'h1;
   end

   int cyc_cnt = 0;
   int last_ack = 0;
   int last_stb = 0;
   int both_hi = 0;
   int en_q[$];
   int clr_q[$];
   int stb_q[$];

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (cnt_en) en_q.push_back(cyc_cnt);
         if (cnt_clr) clr_q.push_back(cyc_cnt);
         if (cnt_en || cnt_clr) begin
            stb_q.push_back(cyc_cnt);
            last_stb = cyc_cnt;
         end
         if (cnt_en && cnt_clr) both_hi++;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic mon_clear();
      en_q.delete();
      clr_q.delete();
      stb_q.delete();
   endtask

   // Entered and left just after a rising edge; ack must rise exactly one cycle after the hit.
   task automatic xfer(input logic w, input logic [2:0] off, input logic [3:0] s,
                       input logic [31:0] wd, output logic [31:0] rd);
      chk("ack_idle", {31'd0, ack}, 32'd0);
      cyc = 1'b1; stb = 1'b1; we = w; sel = s; dat_i = wd;
      adr = BASE | {27'd0, off, 2'b00};
      @(posedge clk); #1;
      chk("ack_rise", {31'd0, ack}, 32'd1);
      rd = dat_o;
      last_ack = cyc_cnt;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; dat_i = 32'h0;
      @(posedge clk); #1;
      chk("ack_fall", {31'd0, ack}, 32'd0);
      chk("dat_idle", dat_o, 32'd0);
      $display("xfer we=%0d off=0x%02h sel=%h wd=%h rd=%h", w, {off, 2'b00}, s, wd, rd);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   typedef struct {
      logic        w;
      logic [2:0]  off;
      logic [3:0]  s;
      logic [31:0] wd;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [31:0] rd;
      logic seen;
      int a0, as_, l, a2, n, found;

      vecs.push_back('{1'b0, 3'd0, 4'hF, 32'h0, 32'h0, "rst_ctrl"});
      vecs.push_back('{1'b0, 3'd1, 4'hF, 32'h0, 32'h0, "rst_status"});
      vecs.push_back('{1'b0, 3'd2, 4'hF, 32'h0, 32'h0, "rst_presc"});
      vecs.push_back('{1'b0, 3'd3, 4'hF, 32'h0, 32'h0, "rst_compare"});
      vecs.push_back('{1'b0, 3'd4, 4'hF, 32'h0, 32'h0, "rst_count"});
      vecs.push_back('{1'b0, 3'd5, 4'hF, 32'h0, 32'h0, "rst_unmapped"});
      vecs.push_back('{1'b1, 3'd2, 4'hF, 32'h1234_ABCD, 32'h0, "wr_presc"});
      vecs.push_back('{1'b0, 3'd2, 4'hF, 32'h0, 32'h0000_ABCD, "rd_presc"});
      vecs.push_back('{1'b1, 3'd2, 4'h2, 32'h0000_5500, 32'h0, "wr_presc_b1"});
      vecs.push_back('{1'b0, 3'd2, 4'hF, 32'h0, 32'h0000_55CD, "rd_presc_b1"});
      vecs.push_back('{1'b1, 3'd3, 4'h1, 32'h1234_56FF, 32'h0, "wr_cmp_b0"});
      vecs.push_back('{1'b0, 3'd3, 4'hF, 32'h0, 32'h0000_00FF, "rd_cmp_b0"});
      vecs.push_back('{1'b1, 3'd0, 4'h1, 32'h0000_000C, 32'h0, "wr_ctrl"});
      vecs.push_back('{1'b1, 3'd0, 4'h0, 32'h0000_0000, 32'h0, "wr_ctrl_nosel"});
      vecs.push_back('{1'b0, 3'd0, 4'hF, 32'h0, 32'h0000_000C, "rd_ctrl"});
      vecs.push_back('{1'b1, 3'd5, 4'hF, 32'hFFFF_FFFF, 32'h0, "wr_unmapped"});
      vecs.push_back('{1'b0, 3'd5, 4'hF, 32'h0, 32'h0, "rd_unmapped"});
      vecs.push_back('{1'b1, 3'd1, 4'hF, 32'h0000_0003, 32'h0, "wr_status_ro"});
      vecs.push_back('{1'b0, 3'd1, 4'hF, 32'h0, 32'h0, "rd_status"});

      do_reset();
      chk("reset_outputs", {27'd0, busy, irq, ack, cnt_en, cnt_clr}, 32'd0);
      chk("reset_dat", dat_o, 32'd0);

      foreach (vecs[i]) begin
         xfer(vecs[i].w, vecs[i].off, vecs[i].s, vecs[i].wd, rd);
         if (!vecs[i].w) chk(vecs[i].name, rd, vecs[i].exp);
      end

      // Address outside the block must never be acknowledged.
      cyc = 1'b1; stb = 1'b1; adr = BASE + 32'h20; seen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         seen = seen | ack;
      end
      cyc = 1'b0; stb = 1'b0;
      chk("miss_no_ack", {31'd0, seen}, 32'd0);

      // Periodic: PRESCALE=3, COMPARE=4.
      xfer(1'b1, 3'd2, 4'hF, 32'd3, rd);
      xfer(1'b1, 3'd3, 4'hF, 32'd4, rd);
      xfer(1'b1, 3'd0, 4'h1, 32'h0C, rd);
      mon_clear();
      xfer(1'b1, 3'd0, 4'h1, 32'h0D, rd);
      a0 = last_ack;
      repeat (45) @(posedge clk);
      #1;
      chk("per_clr_count", {31'd0, clr_q.size() >= 2}, 32'd1);
      if (clr_q.size() >= 2 && en_q.size() >= 1) begin
         chk("per_start_clr", clr_q[0], a0);
         chk("per_first_en", en_q[0], a0 + 4);
         chk("per_match_clr", clr_q[1], a0 + 20);
         n = 0;
         foreach (en_q[i]) if (en_q[i] > clr_q[0] && en_q[i] < clr_q[1]) n++;
         chk("per_en_in_period", n, 4);
      end
      chk("per_irq", {31'd0, irq}, 32'd1);
      chk("per_busy", {31'd0, busy}, 32'd1);
      xfer(1'b0, 3'd1, 4'hF, 32'h0, rd);
      chk("per_status", rd, 32'h5);

      // STOP -> PAUSE, then resume with prescaler phase intact.
      xfer(1'b1, 3'd0, 4'h1, 32'h0E, rd);
      as_ = last_ack;
      l = last_stb;
      mon_clear();
      repeat (50) @(posedge clk);
      #1;
      chk("pause_no_strobe", en_q.size() + clr_q.size(), 0);
      xfer(1'b0, 3'd1, 4'hF, 32'h0, rd);
      chk("pause_status", rd, 32'h6);
      chk("pause_busy", {31'd0, busy}, 32'd1);
      mon_clear();
      xfer(1'b1, 3'd0, 4'h1, 32'h0D, rd);
      a2 = last_ack;
      repeat (10) @(posedge clk);
      #1;
      found = 0;
      foreach (clr_q[i]) if (clr_q[i] == a2) found++;
      chk("resume_no_clr", found, 0);
      chk("resume_strobe_seen", {31'd0, stb_q.size() >= 1}, 32'd1);
      if (stb_q.size() >= 1) chk("resume_phase", (as_ - l) + (stb_q[0] - a2), 5);

      // One-shot: PRESCALE=0, COMPARE=2.
      do_reset();
      xfer(1'b1, 3'd2, 4'hF, 32'd0, rd);
      xfer(1'b1, 3'd3, 4'hF, 32'd2, rd);
      xfer(1'b1, 3'd0, 4'h1, 32'h08, rd);
      mon_clear();
      xfer(1'b1, 3'd0, 4'h1, 32'h09, rd);
      a0 = last_ack;
      repeat (10) @(posedge clk);
      #1;
      chk("os_clr_count", clr_q.size(), 1);
      chk("os_en_count", en_q.size(), 2);
      if (clr_q.size() >= 1) chk("os_start_clr", clr_q[0], a0);
      if (en_q.size() >= 2) begin
         chk("os_en0", en_q[0], a0 + 1);
         chk("os_en1", en_q[1], a0 + 2);
      end
      chk("os_count_hold", {16'd0, cnt_value}, 32'd2);
      chk("os_busy", {31'd0, busy}, 32'd0);
      chk("os_irq", {31'd0, irq}, 32'd1);
      xfer(1'b0, 3'd1, 4'hF, 32'h0, rd);
      chk("os_status_done", rd, 32'h7);

      // CLR from DONE returns to IDLE; W1C clears MATCH and irq.
      xfer(1'b1, 3'd0, 4'h1, 32'h18, rd);
      xfer(1'b0, 3'd1, 4'hF, 32'h0, rd);
      chk("clr_status", rd, 32'h4);
      chk("clr_count", {16'd0, cnt_value}, 32'd0);
      xfer(1'b1, 3'd1, 4'h1, 32'h4, rd);
      xfer(1'b0, 3'd1, 4'hF, 32'h0, rd);
      chk("w1c_status", rd, 32'h0);
      chk("w1c_irq", {31'd0, irq}, 32'd0);

      // START|STOP together from IDLE: STOP wins, nothing happens.
      mon_clear();
      xfer(1'b1, 3'd0, 4'h1, 32'h0B, rd);
      repeat (5) @(posedge clk);
      #1;
      xfer(1'b0, 3'd1, 4'hF, 32'h0, rd);
      chk("startstop_status", rd, 32'h0);
      chk("startstop_no_strobe", stb_q.size(), 0);
      chk("startstop_busy", {31'd0, busy}, 32'd0);

      // Reset while running with a tick every cycle.
      xfer(1'b1, 3'd3, 4'hF, 32'd100, rd);
      mon_clear();
      xfer(1'b1, 3'd0, 4'h1, 32'h0D, rd);
      repeat (5) @(posedge clk);
      #1;
      chk("run_en_seen", {31'd0, en_q.size() > 1}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_cycle_strobes", {30'd0, cnt_en, cnt_clr}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      chk("post_rst_outputs", {27'd0, busy, irq, ack, cnt_en, cnt_clr}, 32'd0);
      chk("post_rst_dat", dat_o, 32'd0);
      xfer(1'b0, 3'd1, 4'hF, 32'h0, rd);
      chk("post_rst_status", rd, 32'h0);
      xfer(1'b0, 3'd5, 4'hF, 32'h0, rd);
      chk("post_rst_unmapped", rd, 32'h0);

      chk("en_clr_exclusive", both_hi, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
